// File: rtl/apu_pkg.sv
// apu_pkg: shared APU field widths, note record and sequencer state encoding
package apu_pkg;
    localparam int PERIOD_W = 11;
    localparam int DUTY_W = 2;
    localparam int LEN_W = 8;
    typedef struct packed {
        logic [PERIOD_W-1:0] period;
        logic [DUTY_W-1:0] duty;
        logic [LEN_W-1:0] len;
    } apu_note_t;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} seq_state_t;
endpackage

// File: rtl/apu_tick_counter.sv
// apu_tick_counter: frame-tick prescaler plus tick down-counter, done on the last cycle of the hold
module apu_tick_counter
    import apu_pkg::*;
#(
    parameter int TICK_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic [LEN_W-1:0] len,
    output logic             done
);
    localparam int PW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_CYCLES - 1);
    logic [PW-1:0] pre_q;
    logic [LEN_W-1:0] ticks_q;
    logic wrap;
    assign wrap = pre_q == PRE_MAX;
    assign done = wrap && ticks_q == LEN_W'(1);
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            pre_q <= '0;
            ticks_q <= '0;
        end else if (start) begin
            pre_q <= '0;
            ticks_q <= len;
        end else if (ticks_q != '0) begin
            pre_q <= wrap ? '0 : pre_q + 1'b1;
            ticks_q <= wrap ? ticks_q - 1'b1 : ticks_q;
        end
    end
endmodule

// File: rtl/apu_note_sequencer.sv
// apu_note_sequencer: plays a loaded note table out over independent period/duty valid-ready channels
module apu_note_sequencer
    import apu_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int TICK_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [PERIOD_W-1:0]      load_period,
    input  logic [DUTY_W-1:0]        load_duty,
    input  logic [LEN_W-1:0]         load_len,
    input  logic                     load_vld,
    output logic                     load_rdy,
    input  logic                     play,
    input  logic                     loop,
    input  logic                     stop,
    output logic                     busy,
    output logic [PERIOD_W-1:0]      period_s,
    output logic                     period_s_vld,
    input  logic                     period_s_rdy,
    output logic [DUTY_W-1:0]        duty_s,
    output logic                     duty_s_vld,
    input  logic                     duty_s_rdy
);
    localparam int AW = $clog2(DEPTH);
    apu_note_t table_q [DEPTH];
    seq_state_t state_q;
    logic [AW-1:0] idx_q, idx_d;
    logic [PERIOD_W-1:0] period_q;
    logic [DUTY_W-1:0] duty_q;
    logic period_vld_q, duty_vld_q, psent_q, dsent_q;
    logic p_done, d_done, arm, tick_start, tick_done;
    apu_note_t cur, arm_note;
    assign cur = table_q[idx_q];
    assign arm_note = table_q[idx_d];
    assign p_done = psent_q | (period_vld_q & period_s_rdy);
    assign d_done = dsent_q | (duty_vld_q & duty_s_rdy);
    assign load_rdy = state_q == S_IDLE;
    assign busy = !load_rdy;
    assign period_s = period_q;
    assign duty_s = duty_q;
    assign period_s_vld = period_vld_q;
    assign duty_s_vld = duty_vld_q;
    // arm: the FSM is about to enter ISSUE at idx_d, so its valids go out on the same edge
    assign arm = (state_q == S_IDLE && play)
              || (state_q == S_ISSUE && cur.len == '0 && loop && idx_q != '0)
              || (state_q == S_HOLD && tick_done);
    assign idx_d = state_q == S_HOLD ? idx_q + 1'b1 : '0;
    assign tick_start = state_q == S_ISSUE && cur.len != '0 && p_done && d_done && !stop;
    always_ff @(posedge clk) begin
        if (load_vld && load_rdy) table_q[load_addr] <= {load_period, load_duty, load_len};
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q <= '0;
            period_q <= '0;
            duty_q <= '0;
            period_vld_q <= 1'b0;
            duty_vld_q <= 1'b0;
            psent_q <= 1'b0;
            dsent_q <= 1'b0;
        end else if (stop) begin
            state_q <= S_IDLE;
            period_vld_q <= 1'b0;
            duty_vld_q <= 1'b0;
            psent_q <= 1'b0;
            dsent_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: state_q <= play ? S_ISSUE : S_IDLE;
                S_ISSUE: begin
                    if (cur.len == '0) begin
                        state_q <= arm ? S_ISSUE : S_IDLE;
                    end else begin
                        period_vld_q <= period_vld_q & ~period_s_rdy;
                        duty_vld_q <= duty_vld_q & ~duty_s_rdy;
                        psent_q <= p_done & ~d_done;
                        dsent_q <= d_done & ~p_done;
                        state_q <= (p_done && d_done) ? S_HOLD : S_ISSUE;
                    end
                end
                S_HOLD: state_q <= tick_done ? S_ISSUE : S_HOLD;
                default: state_q <= S_IDLE;
            endcase
            if (arm) begin
                idx_q <= idx_d;
                if (arm_note.len != '0) begin
                    period_q <= arm_note.period;
                    duty_q <= arm_note.duty;
                    period_vld_q <= 1'b1;
                    duty_vld_q <= 1'b1;
                end
            end
        end
    end
    apu_tick_counter #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
        .clk(clk),
        .rst_n(rst_n),
        .start(tick_start),
        .clear(stop),
        .len(cur.len),
        .done(tick_done)
    );
endmodule

// File: tb/tb_apu_note_sequencer.sv
// tb_apu_note_sequencer: randomized and directed playback checked against a note-level timing model
module tb_apu_note_sequencer;
    localparam int T = 4;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [3:0] load_addr = '0;
    logic [10:0] load_period = '0;
    logic [1:0] load_duty = '0;
    logic [7:0] load_len = '0;
    logic load_vld = 1'b0, load_rdy, play = 1'b0, loop = 1'b0, stop = 1'b0, busy;
    logic [10:0] period_s;
    logic [1:0] duty_s;
    logic period_s_vld, period_s_rdy = 1'b0, duty_s_vld, duty_s_rdy = 1'b0;
    logic [10:0] m_per [16];
    logic [1:0] m_duty [16];
    int m_len [16];
    int n_tests = 0, n_fail = 0;
    always #5 clk = ~clk;
    apu_note_sequencer #(.DEPTH(16), .TICK_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .load_addr(load_addr), .load_period(load_period),
        .load_duty(load_duty), .load_len(load_len), .load_vld(load_vld), .load_rdy(load_rdy),
        .play(play), .loop(loop), .stop(stop), .busy(busy),
        .period_s(period_s), .period_s_vld(period_s_vld), .period_s_rdy(period_s_rdy),
        .duty_s(duty_s), .duty_s_vld(duty_s_vld), .duty_s_rdy(duty_s_rdy)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic check_idle();
        chk("idle_pvld", period_s_vld, 0);
        chk("idle_dvld", duty_s_vld, 0);
        chk("idle_busy", busy, 0);
        chk("idle_load_rdy", load_rdy, 1);
    endtask
    task automatic load(input int a, input int p, input int d, input int l);
        load_addr = 4'(a);
        load_period = 11'(p);
        load_duty = 2'(d);
        load_len = 8'(l);
        load_vld = 1'b1;
        chk("load_rdy_idle", load_rdy, 1);
        @(negedge clk);
        load_vld = 1'b0;
        m_per[a] = 11'(p);
        m_duty[a] = 2'(d);
        m_len[a] = l;
    endtask
    task automatic do_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        period_s_rdy = 1'b0;
        duty_s_rdy = 1'b0;
        check_idle();
    endtask
    // rdy_pct < 0 selects the directed case: duty ready at once, period ready after 4 waits
    task automatic run_play(input bit lp, input int max_notes, input int rdy_pct, input bit stop_hold);
        int i, m, notes, k, hl;
        bit ended, pd, dd, ap, ad;
        loop = lp;
        play = 1'b1;
        @(negedge clk);
        play = 1'b0;
        i = 0;
        notes = 0;
        ended = 0;
        forever begin
            m = 0;
            while (m_len[i] == 0 && !ended) begin
                m++;
                if (lp && i != 0) i = 0;
                else ended = 1;
            end
            repeat (m) begin
                chk("marker_pvld", period_s_vld, 0);
                chk("marker_dvld", duty_s_vld, 0);
                chk("marker_busy", busy, 1);
                @(negedge clk);
            end
            if (ended) begin
                check_idle();
                return;
            end
            chk("issue_pvld", period_s_vld, 1);
            chk("issue_dvld", duty_s_vld, 1);
            chk("issue_period", period_s, m_per[i]);
            chk("issue_duty", duty_s, m_duty[i]);
            chk("issue_load_rdy", load_rdy, 0);
            if (notes == max_notes && !stop_hold) begin
                period_s_rdy = 1'($urandom_range(1));
                duty_s_rdy = 1'($urandom_range(1));
                do_stop();
                return;
            end
            pd = 0;
            dd = 0;
            k = 0;
            while (!(pd && dd)) begin
                period_s_rdy = rdy_pct < 0 ? (k >= 4) : ($urandom_range(99) < rdy_pct);
                duty_s_rdy = rdy_pct < 0 ? 1'b1 : ($urandom_range(99) < rdy_pct);
                ap = period_s_rdy && !pd;
                ad = duty_s_rdy && !dd;
                @(negedge clk);
                pd |= ap;
                dd |= ad;
                k++;
                if (!(pd && dd)) begin
                    chk("hs_pvld", period_s_vld, !pd);
                    chk("hs_dvld", duty_s_vld, !dd);
                    if (!pd) chk("hs_period_stable", period_s, m_per[i]);
                    if (!dd) chk("hs_duty_stable", duty_s, m_duty[i]);
                end
                if (k > 300) begin
                    chk("hs_timeout", 1, 0);
                    return;
                end
            end
            period_s_rdy = 1'b0;
            duty_s_rdy = 1'b0;
            hl = m_len[i] * T;
            for (int h = 0; h < hl; h++) begin
                if (stop_hold && notes + 1 == max_notes && h == hl / 2) begin
                    do_stop();
                    return;
                end
                chk("hold_pvld", period_s_vld, 0);
                chk("hold_dvld", duty_s_vld, 0);
                chk("hold_busy", busy, 1);
                @(negedge clk);
            end
            notes++;
            i = (i + 1) % 16;
        end
    endtask
    task automatic base_table();
        load(0, 'h0FD, 2, 3);
        load(1, 'h1AB, 1, 2);
        load(2, 0, 0, 0);
    endtask
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_pvld", period_s_vld, 0);
        chk("rst_dvld", duty_s_vld, 0);
        chk("rst_period", period_s, 0);
        chk("rst_duty", duty_s, 0);
        chk("rst_busy", busy, 0);
        chk("rst_load_rdy", load_rdy, 1);
        rst_n = 1'b1;
        @(negedge clk);
        base_table();
        run_play(0, 99, 100, 0);
        run_play(0, 99, -1, 0);
        run_play(0, 99, 40, 0);
        run_play(1, 6, 100, 0);
        run_play(0, 2, 100, 1);
        run_play(0, 1, 70, 0);
        run_play(0, 99, 100, 0);
        // loads while busy must be refused and leave the table intact
        loop = 1'b0;
        play = 1'b1;
        @(negedge clk);
        play = 1'b0;
        load_addr = 4'd0;
        load_period = 11'h7FF;
        load_duty = 2'd3;
        load_len = 8'd5;
        load_vld = 1'b1;
        repeat (3) begin
            chk("busy_load_rdy", load_rdy, 0);
            chk("busy_period_stable", period_s, 'h0FD);
            @(negedge clk);
        end
        load_vld = 1'b0;
        do_stop();
        run_play(0, 99, 100, 0);
        // reset in the middle of a hold
        play = 1'b1;
        @(negedge clk);
        play = 1'b0;
        period_s_rdy = 1'b1;
        duty_s_rdy = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        period_s_rdy = 1'b0;
        duty_s_rdy = 1'b0;
        chk("mid_rst_period", period_s, 0);
        chk("mid_rst_duty", duty_s, 0);
        check_idle();
        run_play(0, 99, 100, 0);
        load(0, 'h123, 1, 0);
        run_play(1, 99, 100, 0);
        for (int a = 0; a < 16; a++) load(a, $urandom_range(2047), $urandom_range(3), 1);
        run_play(0, 20, 80, 0);
        repeat (6) begin
            for (int a = 0; a < 16; a++)
                load(a, $urandom_range(2047), $urandom_range(3),
                     $urandom_range(3) == 0 ? 0 : $urandom_range(1, 3));
            run_play(1'($urandom_range(1)), $urandom_range(2, 8), $urandom_range(30, 100),
                     1'($urandom_range(1)));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
